// File: rtl/rs_syndrome_calculator_if.sv
// Handshake and control bundle between the codeword source, the syndrome block and its reader.
// No latency of its own; it only groups the wires.
// in_valid/in_ready is a plain valid-ready pair; a symbol moves when both are high at a clock edge.
interface rs_syndrome_calculator_if #(
    parameter int AW = 4
);
    logic          start;
    logic [7:0]    first_root;
    logic [7:0]    generator;
    logic [7:0]    num_symbols;
    logic [56:0]   reduction_matrix;
    logic          in_valid;
    logic [7:0]    in_symbol;
    logic          in_ready;
    logic          busy;
    logic          done;
    logic          no_errors;
    logic [AW-1:0] syn_addr;
    logic [7:0]    syn_data;

    modport master (
        output start, first_root, generator, num_symbols, reduction_matrix,
        output in_valid, in_symbol, syn_addr,
        input  in_ready, busy, done, no_errors, syn_data
    );

    modport slave (
        input  start, first_root, generator, num_symbols, reduction_matrix,
        input  in_valid, in_symbol, syn_addr,
        output in_ready, busy, done, no_errors, syn_data
    );
endinterface

// File: rtl/rs_syndrome_calculator.sv
// Reed-Solomon syndrome calculator: S_j = R(root_j) over GF(2^8) by Horner's rule, one shared multiplier.
// Latency start->done is 1 + (NSYM-1) + n*(NSYM+1) cycles; one symbol accepted per NSYM+1 cycles.
// in_ready is high only while waiting for a symbol; the source may stall freely, nothing is dropped.
module rs_syndrome_calculator #(
    parameter int NSYM = 16,
    parameter int AW   = $clog2(NSYM)
) (
    input  logic                   clk,
    input  logic                   rst,
    rs_syndrome_calculator_if.slave bus
);
    typedef enum logic [2:0] {IDLE, INIT, ACCEPT, UPDATE, DONE} state_t;

    localparam logic [AW-1:0] LAST = AW'(NSYM - 1);

    state_t        state;
    logic [7:0]    syn  [NSYM];
    logic [7:0]    root [NSYM];
    logic [7:0]    gen_q;
    logic [7:0]    nsym_q;
    logic [7:0]    cnt;
    logic [7:0]    sym_q;
    logic [AW-1:0] idx;
    logic          in_ready_q;
    logic          busy_q;
    logic          done_q;
    logic          no_errors_q;

    logic [7:0]    mul_a;
    logic [7:0]    mul_b;
    logic [7:0]    mul_p;
    logic [7:0]    upd_val;
    logic          rest_zero;
    logic [7:0]    syn_rd [2**AW];

    // Top bit of the reduction matrix carries no coefficient for GF(2^8).
    logic          unused_rm_reserved;
    assign unused_rm_reserved = bus.reduction_matrix[56];

    // Mastrovito multiply: carry-less product, then fold x^8..x^14 back in
    // using row k of the matrix, which holds x^(8+k) mod p.
    function automatic logic [7:0] finite_field_multiplier_mastravito(
        input logic [7:0]  a,
        input logic [7:0]  b,
        input logic [55:0] rm
    );
        logic [14:0] raw;
        logic [7:0]  p;
        raw = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) raw = raw ^ (15'(a) << i);
        end
        p = raw[7:0];
        for (int k = 0; k < 7; k++) begin
            if (raw[8+k]) p = p ^ rm[8*k +: 8];
        end
        return p;
    endfunction

    // Operand mux for the shared multiplier: root chain in INIT, Horner step otherwise.
    always_comb begin
        mul_a = syn[idx];
        mul_b = root[idx];
        if (state == INIT) begin
            mul_a = root[idx - AW'(1)];
            mul_b = gen_q;
        end
    end

    assign mul_p   = finite_field_multiplier_mastravito(mul_a, mul_b, bus.reduction_matrix[55:0]);
    assign upd_val = mul_p ^ sym_q;

    // All syndromes except the last are final when the last one is written.
    always_comb begin
        rest_zero = 1'b1;
        for (int i = 0; i < NSYM - 1; i++) begin
            if (syn[i] != 8'h00) rest_zero = 1'b0;
        end
    end

    // Read port padded to the full address space; addresses past NSYM read zero.
    for (genvar g = 0; g < 2**AW; g++) begin : g_rd
        if (g < NSYM) begin : g_live
            assign syn_rd[g] = syn[g];
        end else begin : g_pad
            assign syn_rd[g] = 8'h00;
        end
    end

    assign bus.syn_data  = syn_rd[bus.syn_addr];
    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.no_errors = no_errors_q;

    // Control FSM with root chain, syndrome registers and registered status flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            for (int i = 0; i < NSYM; i++) begin
                syn[i]  <= 8'h00;
                root[i] <= 8'h00;
            end
            gen_q       <= 8'h00;
            nsym_q      <= 8'h00;
            cnt         <= 8'h00;
            sym_q       <= 8'h00;
            idx         <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            no_errors_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        root[0]     <= bus.first_root;
                        gen_q       <= bus.generator;
                        nsym_q      <= bus.num_symbols;
                        for (int i = 0; i < NSYM; i++) syn[i] <= 8'h00;
                        cnt         <= 8'h00;
                        idx         <= AW'(1);
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        no_errors_q <= 1'b0;
                        state       <= INIT;
                    end
                end
                INIT: begin
                    root[idx] <= mul_p;
                    if (idx == LAST) begin
                        idx <= '0;
                        if (nsym_q == 8'h00) begin
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            no_errors_q <= 1'b1;
                            state       <= DONE;
                        end else begin
                            in_ready_q  <= 1'b1;
                            state       <= ACCEPT;
                        end
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
                ACCEPT: begin
                    if (bus.in_valid && in_ready_q) begin
                        sym_q      <= bus.in_symbol;
                        idx        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= UPDATE;
                    end
                end
                UPDATE: begin
                    syn[idx] <= upd_val;
                    if (idx == LAST) begin
                        idx <= '0;
                        cnt <= cnt + 8'd1;
                        if (cnt + 8'd1 == nsym_q) begin
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            no_errors_q <= rest_zero && (upd_val == 8'h00);
                            state       <= DONE;
                        end else begin
                            in_ready_q  <= 1'b1;
                            state       <= ACCEPT;
                        end
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rs_syndrome_calculator.sv
// Bench for rs_syndrome_calculator: directed vector table, corner sequences and randomized runs.
// Expected syndromes come from direct polynomial evaluation over GF(2^8) with p = 0x11d.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_rs_syndrome_calculator;
    localparam int NSYM  = 4;
    localparam int AW    = $clog2(NSYM);
    localparam int LIMIT = 4000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rs_syndrome_calculator_if #(.AW(AW)) bus_if ();
    rs_syndrome_calculator #(.NSYM(NSYM), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus_if));

    typedef struct packed {
        logic [7:0]      fr;
        logic [7:0]      gen;
        logic [7:0]      n;
        logic [3:0][7:0] sym;
        logic [3:0][7:0] s;
        logic            ne;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sym_buf [256];
    logic [7:0] exp_s   [NSYM];
    logic       exp_ne;
    vec_t       vecs    [6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] aa;
        logic [7:0] p;
        aa = {1'b0, a};
        p  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa[7:0];
            aa = aa << 1;
            if (aa[8]) aa = aa ^ 9'h11d;
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_pow(input logic [7:0] x, input int e);
        logic [7:0] p;
        p = 8'h01;
        for (int i = 0; i < e; i++) p = gf_mul(p, x);
        return p;
    endfunction

    // S_j = sum_i c_i * r_j^(n-1-i) with r_j = fr * gen^j
    task automatic compute_expected(input logic [7:0] fr, input logic [7:0] gen, input int n);
        logic [7:0] r;
        logic [7:0] s;
        exp_ne = 1'b1;
        for (int j = 0; j < NSYM; j++) begin
            r = gf_mul(fr, gf_pow(gen, j));
            s = 8'h00;
            for (int i = 0; i < n; i++) s = s ^ gf_mul(sym_buf[i], gf_pow(r, n - 1 - i));
            exp_s[j] = s;
            if (s != 8'h00) exp_ne = 1'b0;
        end
    endtask

    task automatic read_syn(input int a, output logic [7:0] d);
        bus_if.syn_addr = AW'(a);
        #1;
        d = bus_if.syn_data;
    endtask

    task automatic check_idle(input string tag);
        logic [7:0] d;
        check({tag, "_busy"}, int'(bus_if.busy), 0);
        check({tag, "_done"}, int'(bus_if.done), 0);
        check({tag, "_in_ready"}, int'(bus_if.in_ready), 0);
        check({tag, "_no_errors"}, int'(bus_if.no_errors), 0);
        for (int a = 0; a < NSYM; a++) begin
            read_syn(a, d);
            check($sformatf("%s_syn%0d", tag, a), int'(d), 0);
        end
    endtask

    task automatic check_result(input string tag);
        logic [7:0] d;
        check({tag, "_done"}, int'(bus_if.done), 1);
        check({tag, "_busy"}, int'(bus_if.busy), 0);
        check({tag, "_in_ready"}, int'(bus_if.in_ready), 0);
        check({tag, "_no_errors"}, int'(bus_if.no_errors), int'(exp_ne));
        for (int a = 0; a < NSYM; a++) begin
            read_syn(a, d);
            check($sformatf("%s_S%0d", tag, a), int'(d), int'(exp_s[a]));
        end
    endtask

    // One codeword from start to done. rand_valid inserts source stalls, disturb injects
    // ignored start/in_valid pulses, rst_at >= 0 pulls reset at that cycle and returns.
    task automatic run(input logic [7:0] fr, input logic [7:0] gen, input int n,
                       input bit rand_valid, input bit disturb, input int rst_at,
                       output int lat, output int pulses, output int accepted, output bit spacing_ok);
        int         cyc;
        int         last_rise;
        int         first_acc;
        bit         prev_rdy;
        bit         acc_next;
        bit         first_rdy;
        logic [7:0] d;
        lat = -1; pulses = 0; accepted = 0; spacing_ok = 1'b1;
        last_rise = -1; first_acc = -1; prev_rdy = 1'b0; acc_next = 1'b0; first_rdy = 1'b0;
        @(negedge clk);
        bus_if.start       = 1'b1;
        bus_if.first_root  = fr;
        bus_if.generator   = gen;
        bus_if.num_symbols = 8'(n);
        bus_if.in_valid    = 1'b0;
        @(negedge clk);
        bus_if.start = 1'b0;
        cyc = 1;
        check("start_busy", int'(bus_if.busy), 1);
        check("start_done", int'(bus_if.done), 0);
        for (int a = 0; a < NSYM; a++) begin
            read_syn(a, d);
            check($sformatf("start_clear_S%0d", a), int'(d), 0);
        end
        while (cyc < LIMIT) begin
            if (acc_next) begin
                accepted++;
                if (first_acc < 0) first_acc = cyc;
            end
            acc_next = 1'b0;
            if (bus_if.done) break;
            if (cyc == rst_at) begin
                rst = 1'b0;
                bus_if.in_valid = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                check_idle("mid_reset");
                return;
            end
            bus_if.first_root  = 8'($urandom);
            bus_if.generator   = 8'($urandom);
            bus_if.num_symbols = 8'($urandom);
            if (bus_if.in_ready && !prev_rdy) begin
                pulses++;
                if (last_rise >= 0 && cyc - last_rise != NSYM + 1) spacing_ok = 1'b0;
                last_rise = cyc;
            end
            prev_rdy = bus_if.in_ready;
            bus_if.start    = 1'b0;
            bus_if.in_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus_if.in_ready && accepted < n) bus_if.in_symbol = sym_buf[accepted];
            else bus_if.in_symbol = 8'($urandom);
            if (disturb) begin
                if (bus_if.busy && !bus_if.in_ready && first_acc < 0) bus_if.in_valid = 1'b1;
                if (bus_if.in_ready && !first_rdy) begin
                    first_rdy       = 1'b1;
                    bus_if.start    = 1'b1;
                    bus_if.in_valid = 1'b0;
                end
                if (cyc == first_acc) bus_if.start = 1'b1;
            end
            acc_next = bus_if.in_ready && bus_if.in_valid;
            @(negedge clk);
            cyc++;
        end
        bus_if.in_valid = 1'b0;
        bus_if.start    = 1'b0;
        if (cyc >= LIMIT) check("done_timeout", cyc, -1);
        else lat = cyc;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         lat;
        int         pulses;
        int         acc;
        bit         sp_ok;
        int         n;
        logic [7:0] fr;
        logic [7:0] gen;
        logic [7:0] row;
        logic [56:0] rm;

        // x^(8+k) mod 0x11d, one byte per row
        rm  = '0;
        row = 8'h1d;
        for (int k = 0; k < 7; k++) begin
            rm[8*k +: 8] = row;
            row = (row << 1) ^ (row[7] ? 8'h1d : 8'h00);
        end
        bus_if.reduction_matrix = rm;
        bus_if.start = 1'b0; bus_if.first_root = 8'h00; bus_if.generator = 8'h00;
        bus_if.num_symbols = 8'h00; bus_if.in_valid = 1'b0; bus_if.in_symbol = 8'h00;
        bus_if.syn_addr = '0;

        vecs[0] = '{fr:8'h01, gen:8'h02, n:8'd1, sym:32'h00000005, s:32'h05050505, ne:1'b0};
        vecs[1] = '{fr:8'h01, gen:8'h02, n:8'd2, sym:32'h00000001, s:32'h08040201, ne:1'b0};
        vecs[2] = '{fr:8'h02, gen:8'h02, n:8'd2, sym:32'h00000101, s:32'h11090503, ne:1'b0};
        vecs[3] = '{fr:8'h01, gen:8'h02, n:8'd3, sym:32'h00000000, s:32'h00000000, ne:1'b1};
        vecs[4] = '{fr:8'h01, gen:8'h02, n:8'd0, sym:32'h00000000, s:32'h00000000, ne:1'b1};
        vecs[5] = '{fr:8'h80, gen:8'h02, n:8'd2, sym:32'h00000001, s:32'h743a1d80, ne:1'b0};

        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b1;

        // Directed table, in_valid held high
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 4; i++) sym_buf[i] = vecs[v].sym[i];
            for (int j = 0; j < NSYM; j++) exp_s[j] = vecs[v].s[j];
            exp_ne = vecs[v].ne;
            n = int'(vecs[v].n);
            run(vecs[v].fr, vecs[v].gen, n, 1'b0, 1'b0, -1, lat, pulses, acc, sp_ok);
            check($sformatf("vec%0d_latency", v), lat, 1 + (NSYM - 1) + n * (NSYM + 1));
            check($sformatf("vec%0d_ready_pulses", v), pulses, n);
            check($sformatf("vec%0d_accepted", v), acc, n);
            check($sformatf("vec%0d_spacing", v), int'(sp_ok), 1);
            check_result($sformatf("vec%0d", v));
        end

        // 255 zero symbols back to back
        for (int i = 0; i < 255; i++) sym_buf[i] = 8'h00;
        for (int j = 0; j < NSYM; j++) exp_s[j] = 8'h00;
        exp_ne = 1'b1;
        run(8'h01, 8'h02, 255, 1'b0, 1'b0, -1, lat, pulses, acc, sp_ok);
        check("long_ready_pulses", pulses, 255);
        check("long_spacing", int'(sp_ok), 1);
        check("long_latency", lat, 1 + (NSYM - 1) + 255 * (NSYM + 1));
        check_result("long");

        // Reset in the second UPDATE cycle, then a clean rerun
        for (int i = 0; i < 4; i++) sym_buf[i] = vecs[1].sym[i];
        run(8'h01, 8'h02, 2, 1'b0, 1'b0, 6, lat, pulses, acc, sp_ok);
        for (int j = 0; j < NSYM; j++) exp_s[j] = vecs[1].s[j];
        exp_ne = 1'b0;
        run(8'h01, 8'h02, 2, 1'b0, 1'b0, -1, lat, pulses, acc, sp_ok);
        check("after_reset_latency", lat, 1 + (NSYM - 1) + 2 * (NSYM + 1));
        check_result("after_reset");

        // Ignored start and in_valid pulses; then a restart straight from DONE
        run(8'h01, 8'h02, 2, 1'b0, 1'b1, -1, lat, pulses, acc, sp_ok);
        check("disturb_accepted", acc, 2);
        check_result("disturb");
        for (int i = 0; i < 4; i++) sym_buf[i] = vecs[2].sym[i];
        for (int j = 0; j < NSYM; j++) exp_s[j] = vecs[2].s[j];
        run(8'h02, 8'h02, 2, 1'b0, 1'b0, -1, lat, pulses, acc, sp_ok);
        check_result("restart");

        // Randomized codewords with source stalls against the evaluation model
        for (int t = 0; t < 12; t++) begin
            n   = $urandom_range(0, 12);
            fr  = 8'($urandom_range(1, 255));
            gen = 8'($urandom_range(1, 255));
            for (int i = 0; i < n; i++) sym_buf[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            if (t % 4 == 1) for (int i = 0; i < n; i++) sym_buf[i] = 8'h00;
            compute_expected(fr, gen, n);
            run(fr, gen, n, 1'b1, 1'b0, -1, lat, pulses, acc, sp_ok);
            check($sformatf("rand%0d_accepted", t), acc, n);
            check_result($sformatf("rand%0d", t));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rs_syndrome_calculator.md
Name: rs_syndrome_calculator

Overview:
- Computes the 2t Reed-Solomon syndromes S_j = R(root_j), j = 0..NSYM-1, over GF(2^8) from a streamed received codeword, using Horner's rule.
- Sits between the codeword input path and the error-locator stage.
- Consumes alpha^fcr from the binary exponentiation unit as first_root, and builds the remaining roots itself by repeated multiplication by generator.
- Uses one shared combinational finite_field_multiplier_mastravito, time-multiplexed over the syndromes.

Parameters:
- NSYM, 16: number of syndromes (2t), range 2..32.
- AW, $clog2(NSYM): syndrome read-address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-low.
- start  in  1  begin a codeword; sampled only in IDLE or DONE.
- first_root  in  8  alpha^fcr, taken from the exponentiation unit's result; latched on start.
- generator  in  8  alpha; latched on start.
- num_symbols  in  8  codeword length n, 0..255; latched on start.
- reduction_matrix  in  57  field reduction matrix, same format as the codebase multiplier; must be held stable while busy.
- in_valid  in  1  in_symbol is valid.
- in_symbol  in  8  received symbol; highest-degree coefficient first.
- in_ready  out  1  block accepts a symbol this cycle.
- busy  out  1  high in INIT, ACCEPT and UPDATE.
- done  out  1  high in DONE; all syndromes final.
- no_errors  out  1  in DONE: all syndromes are zero.
- syn_addr  in  AW  syndrome read index.
- syn_data  out  8  combinational S[syn_addr]; 0 if syn_addr >= NSYM.

Behaviour:
- Reset (rst==0 at a clock edge), in any state including mid-operation:
  - state = IDLE.
  - All S[j] = 0, all root[j] = 0, counters = 0.
  - in_ready = 0, busy = 0, done = 0, no_errors = 0.
- States: IDLE, INIT, ACCEPT, UPDATE, DONE.
- IDLE or DONE with start=1:
  - Latch root[0] = first_root, generator and num_symbols.
  - Clear all S[j] and the symbol counter; done = 0.
  - Go to INIT with k = 1.
- INIT: one multiply per cycle, root[k] <= root[k-1] * generator, for k = 1..NSYM-1 (NSYM-1 cycles). Then:
  - If num_symbols == 0, go to DONE.
  - Otherwise go to ACCEPT.
- ACCEPT:
  - in_ready = 1 (registered output, high only in ACCEPT).
  - On in_valid & in_ready: latch in_symbol, set j = 0, go to UPDATE.
- UPDATE:
  - Each cycle: S[j] <= S[j] * root[j] XOR sym; j++.
  - Lasts exactly NSYM cycles; in_ready = 0 throughout.
  - After j = NSYM-1, increment the symbol count.
  - If count == num_symbols, go to DONE; else go to ACCEPT.
- Throughput: one symbol per NSYM+1 cycles when in_valid is held high.
- Latency from start to done: 1 + (NSYM-1) + n*(NSYM+1) cycles.
- DONE:
  - done = 1 and no_errors = (all S == 0), both registered and held until the next start or reset.
  - in_ready = 0.
  - start in DONE restarts exactly as from IDLE.
- start while busy is ignored.
- in_valid outside ACCEPT is ignored; no symbol is lost or duplicated.
- Multiplier inputs are muxed from state (INIT: root[k-1], generator; UPDATE: S[j], root[j]). GF addition is XOR.
- syn_data is readable in every state. It reflects partial results while busy and zeros after reset or start.
- Changing first_root, generator or num_symbols after start has no effect on the run in progress.

Test Plan:
All scenarios use reduction_matrix for polynomial 0x11d.
1. NSYM=4, first_root=0x01, generator=0x02, n=1, symbol 0x05 -> done at cycle 1+3+5=9 after start; S = 05,05,05,05; no_errors=0.
2. NSYM=4, fcr roots 01,02,04,08, n=2, symbols [0x01,0x00] -> S = 01,02,04,08; done=1; no_errors=0.
3. n=255, all symbols 0x00, in_valid held high -> in_ready pulses exactly 255 times, each in_ready pulse NSYM+1 cycles after the previous one; all S = 0; no_errors=1.
4. n=0 -> done asserts NSYM cycles after start; in_ready never high; no_errors=1.
5. rst=0 in the second UPDATE cycle -> next cycle busy=0, done=0, in_ready=0, syn_data=0 for every address. A following start with scenario 2 reproduces its results exactly.
6. start pulsed during ACCEPT and during UPDATE, and in_valid pulsed during INIT -> all ignored; results identical to an undisturbed run of scenario 2. start in DONE clears syndromes and reruns.
